id_stage: RTL and testbench

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of instruction fetch. Holds the IF/ID pipeline register, the 32×32 register file with write-back port, sign extension, and early branch resolution (beq/bne). Produces the branch-redirect signals that fetch consumes: `PCSrcD`, `PCBranch`, `PCD`, `JumpPredictD`. Detects branch-prediction mismatches and squashes the wrongly fetched instruction.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/id_stage_if.sv | 47 ++++
 rtl/id_stage_regfile.sv | 54 +++++
 rtl/id_stage.sv | 88 ++++++++
 tb/tb_id_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, bubble encoding, instruction field positions.
// Also the IF/ID pipeline register layout used by the decode stage.
// No logic; imported by the decode stage, its register file and its interface.
package mips_pkg;

   localparam logic [5:0]  OP_BEQ    = 6'b000100;
   localparam logic [5:0]  OP_BNE    = 6'b000101;
   localparam logic [5:0]  OP_RTYPE  = 6'b000000;

   // All-zero word decodes as sll r0,r0,0: the pipeline bubble.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        jump_predict;
   } ifid_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch/hazard/write-back inputs and decode outputs.
// master = the surrounding pipeline (drives fetch, hazard and write-back signals).
// slave  = id_stage (drives the IF/ID contents and decode results).
interface id_stage_if;
   import mips_pkg::*;

   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        JumpPredictF;
   logic        StallD;
   logic        ForwardAD;
   logic        ForwardBD;
   logic [31:0] ALUOutM;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;

   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        JumpPredictD;
   logic [31:0] RD1D;
   logic [31:0] RD2D;
   logic [4:0]  RsD;
   logic [4:0]  RtD;
   logic [4:0]  RdD;
   logic [31:0] SignImmD;
   logic [31:0] PCBranch;
   logic        PCSrcD;
   logic        MispredictD;

   modport master (
      output InstrF, PCF, PCPlus4F, JumpPredictF, StallD, ForwardAD, ForwardBD,
             ALUOutM, RegWriteW, WriteRegW, ResultW,
      input  InstrD, PCD, PCPlus4D, JumpPredictD, RD1D, RD2D, RsD, RtD, RdD,
             SignImmD, PCBranch, PCSrcD, MispredictD
   );

   modport slave (
      input  InstrF, PCF, PCPlus4F, JumpPredictF, StallD, ForwardAD, ForwardBD,
             ALUOutM, RegWriteW, WriteRegW, ResultW,
      output InstrD, PCD, PCPlus4D, JumpPredictD, RD1D, RD2D, RsD, RtD, RdD,
             SignImmD, PCBranch, PCSrcD, MispredictD
   );

endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two combinational read ports, one write port, r0 hardwired to 0.
// Ports: clk, rst (sync, active-high, clears all entries), ra1/ra2 -> rd1/rd2, we/wa/wd write.
// A same-cycle write to a read address is bypassed to the read port.
module regfile
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   always_comb begin
      rf_d = rf_q;
      if (we && (wa != 5'd0)) begin
         rf_d[wa] = wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'h0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   function automatic logic [31:0] read_port(input logic [4:0] ra);
      logic [31:0] val;
      if (ra == 5'd0) begin
         val = 32'h0;
      end else if (we && (wa == ra)) begin
         // Write-back in the same cycle wins so decode never sees a stale operand.
         val = wd;
      end else begin
         val = rf_q[ra];
      end
      return val;
   endfunction

   assign rd1 = read_port(ra1);
   assign rd2 = read_port(ra2);

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file, sign extension, beq/bne resolution.
// Ports: clk, rst (sync, active-high), bus (id_stage_if.slave) carrying fetch, hazard,
// forwarding and write-back inputs plus the decoded outputs and the branch redirect to fetch.
module id_stage
   import mips_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   id_stage_if.slave     bus
);

   ifid_t       ifid_q;
   ifid_t       ifid_d;

   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] cmp_a;
   logic [31:0] cmp_b;
   logic [31:0] sign_imm;
   logic [5:0]  opcode;
   logic        is_beq;
   logic        is_bne;
   logic        pcsrc;
   logic        mispredict;

   // Stall outranks the flush: a held branch re-evaluates its mismatch next cycle.
   always_comb begin
      ifid_d = ifid_q;
      if (!bus.StallD) begin
         if (mispredict) begin
            ifid_d = '0;
            ifid_d.instr = NOP_INSTR;
         end else begin
            ifid_d.instr        = bus.InstrF;
            ifid_d.pc           = bus.PCF;
            ifid_d.pc_plus4     = bus.PCPlus4F;
            ifid_d.jump_predict = bus.JumpPredictF;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ifid_q <= '0;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   regfile u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (ifid_q.instr[RS_MSB:RS_LSB]),
      .ra2 (ifid_q.instr[RT_MSB:RT_LSB]),
      .we  (bus.RegWriteW),
      .wa  (bus.WriteRegW),
      .wd  (bus.ResultW),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   assign sign_imm = sign_ext16(ifid_q.instr[IMM_MSB:IMM_LSB]);
   assign opcode   = ifid_q.instr[OP_MSB:OP_LSB];
   assign is_beq   = (opcode == OP_BEQ);
   assign is_bne   = (opcode == OP_BNE);

   // Early branch compare uses the memory-stage result when the hazard unit forwards it.
   assign cmp_a = bus.ForwardAD ? bus.ALUOutM : rd1;
   assign cmp_b = bus.ForwardBD ? bus.ALUOutM : rd2;

   assign pcsrc      = (is_beq && (cmp_a == cmp_b)) || (is_bne && (cmp_a != cmp_b));
   assign mispredict = pcsrc ^ ifid_q.jump_predict;

   assign bus.InstrD       = ifid_q.instr;
   assign bus.PCD          = ifid_q.pc;
   assign bus.PCPlus4D     = ifid_q.pc_plus4;
   assign bus.JumpPredictD = ifid_q.jump_predict;
   assign bus.RD1D         = rd1;
   assign bus.RD2D         = rd2;
   assign bus.RsD          = ifid_q.instr[RS_MSB:RS_LSB];
   assign bus.RtD          = ifid_q.instr[RT_MSB:RT_LSB];
   assign bus.RdD          = ifid_q.instr[RD_MSB:RD_LSB];
   assign bus.SignImmD     = sign_imm;
   assign bus.PCBranch     = ifid_q.pc_plus4 + {sign_imm[29:0], 2'b00};
   assign bus.PCSrcD       = pcsrc;
   assign bus.MispredictD  = mispredict;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   id_stage_if bus();

   id_stage u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model: architectural registers and the decode-stage latch.
   logic [31:0] m_regs [32];
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic [31:0] m_pc4;
   logic        m_jp;

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (bus.RegWriteW && bus.WriteRegW == a) return bus.ResultW;
      return m_regs[a];
   endfunction

   function automatic logic [31:0] m_simm();
      int s;
      s = int'($signed(m_instr[15:0]));
      return 32'(s);
   endfunction

   function automatic logic m_taken();
      logic [31:0] a;
      logic [31:0] b;
      int op;
      op = int'(m_instr >> 26);
      a  = bus.ForwardAD ? bus.ALUOutM : m_read(m_instr[25:21]);
      b  = bus.ForwardBD ? bus.ALUOutM : m_read(m_instr[20:16]);
      if (op == 4) return a == b;
      if (op == 5) return a != b;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".InstrD"},   bus.InstrD, m_instr);
      chk({tag, ".PCD"},      bus.PCD, m_pc);
      chk({tag, ".PCPlus4D"}, bus.PCPlus4D, m_pc4);
      chk({tag, ".JPD"},      32'(bus.JumpPredictD), 32'(m_jp));
      chk({tag, ".RD1D"},     bus.RD1D, m_read(m_instr[25:21]));
      chk({tag, ".RD2D"},     bus.RD2D, m_read(m_instr[20:16]));
      chk({tag, ".RsRtRd"},   {17'h0, bus.RsD, bus.RtD, bus.RdD}, {17'h0, m_instr[25:11]});
      chk({tag, ".SignImmD"}, bus.SignImmD, m_simm());
      chk({tag, ".PCBranch"}, bus.PCBranch, m_pc4 + m_simm() * 4);
      chk({tag, ".PCSrcD"},   32'(bus.PCSrcD), 32'(m_taken()));
      chk({tag, ".MispredD"}, 32'(bus.MispredictD), 32'(m_taken() != m_jp));
   endtask

   // Advance one clock; the model absorbs the inputs held across the edge.
   task automatic tick();
      logic mis;
      mis = m_taken() != m_jp;
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 32'h0;
         m_instr = 0; m_pc = 0; m_pc4 = 0; m_jp = 0;
      end else begin
         if (bus.RegWriteW && bus.WriteRegW != 0) m_regs[bus.WriteRegW] = bus.ResultW;
         if (!bus.StallD) begin
            if (mis) begin
               m_instr = 0; m_pc = 0; m_pc4 = 0; m_jp = 0;
            end else begin
               m_instr = bus.InstrF; m_pc = bus.PCF; m_pc4 = bus.PCPlus4F; m_jp = bus.JumpPredictF;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
      bus.InstrF = 32'h0; bus.JumpPredictF = 1'b0;
      bus.RegWriteW = 1'b1; bus.WriteRegW = r; bus.ResultW = v;
      tick();
      bus.RegWriteW = 1'b0;
   endtask

   initial begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_instr = 0; m_pc = 0; m_pc4 = 0; m_jp = 0;
      rst = 1'b1;
      bus.InstrF = 32'h1022_0003; bus.PCF = 32'h0; bus.PCPlus4F = 32'h0; bus.JumpPredictF = 1'b0;
      bus.StallD = 1'b0; bus.ForwardAD = 1'b0; bus.ForwardBD = 1'b0; bus.ALUOutM = 32'h0;
      bus.RegWriteW = 1'b0; bus.WriteRegW = 5'd0; bus.ResultW = 32'h0;

      // Reset
      tick();
      rst = 1'b0;
      bus.InstrF = 32'h00A0_0000;  // rs = r5
      #1;
      chk("rst_instr", bus.InstrD, 32'h0);
      chk("rst_pcd", bus.PCD, 32'h0);
      chk("rst_pc4", bus.PCPlus4D, 32'h0);
      chk("rst_jp", 32'(bus.JumpPredictD), 32'h0);
      chk("rst_pcsrc", 32'(bus.PCSrcD), 32'h0);
      check_all("rst");
      tick();
      chk("r5_after_rst", bus.RD1D, 32'h0);

      // r0 write is discarded, and not bypassed either
      bus.InstrF = 32'h0;
      tick();
      bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd0; bus.ResultW = 32'hFFFF;
      #1;
      chk("r0_bypass", bus.RD1D, 32'h0);
      tick();
      bus.RegWriteW = 1'b0;
      #1;
      chk("r0_stored", bus.RD1D, 32'h0);

      // Write-through on r8
      bus.InstrF = 32'h0100_0000;
      tick();
      bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd8; bus.ResultW = 32'h1234;
      #1;
      chk("wt_same", bus.RD1D, 32'h1234);
      tick();
      bus.RegWriteW = 1'b0;
      #1;
      chk("wt_next", bus.RD1D, 32'h1234);

      // beq taken, not predicted
      set_reg(5'd1, 32'd5);
      set_reg(5'd2, 32'd5);
      bus.InstrF = 32'h1022_0003; bus.PCF = 32'h40; bus.PCPlus4F = 32'h44; bus.JumpPredictF = 1'b0;
      tick();
      bus.InstrF = 32'h2000_0000; bus.PCF = 32'h44; bus.PCPlus4F = 32'h48;
      #1;
      chk("beq_pcsrc", 32'(bus.PCSrcD), 32'h1);
      chk("beq_target", bus.PCBranch, 32'h50);
      chk("beq_pcd", bus.PCD, 32'h40);
      chk("beq_mis", 32'(bus.MispredictD), 32'h1);
      check_all("beq");
      tick();
      chk("beq_flush_instr", bus.InstrD, 32'h0);
      chk("beq_flush_pcd", bus.PCD, 32'h0);
      chk("beq_flush_mis", 32'(bus.MispredictD), 32'h0);

      // bne backward, predicted taken
      set_reg(5'd1, 32'd3);
      set_reg(5'd2, 32'd4);
      bus.InstrF = 32'h1422_FFFE; bus.PCF = 32'h40; bus.PCPlus4F = 32'h44; bus.JumpPredictF = 1'b1;
      tick();
      bus.InstrF = 32'h0022_1820; bus.PCF = 32'h3C; bus.PCPlus4F = 32'h40; bus.JumpPredictF = 1'b0;
      #1;
      chk("bne_target", bus.PCBranch, 32'h3C);
      chk("bne_pcsrc", 32'(bus.PCSrcD), 32'h1);
      chk("bne_mis", 32'(bus.MispredictD), 32'h0);
      tick();
      chk("bne_next", bus.InstrD, 32'h0022_1820);
      set_reg(5'd2, 32'd3);
      bus.InstrF = 32'h1422_FFFE; bus.PCF = 32'h40; bus.PCPlus4F = 32'h44; bus.JumpPredictF = 1'b1;
      tick();
      bus.InstrF = 32'h0022_1820; bus.JumpPredictF = 1'b0;
      #1;
      chk("bne_nt_pcsrc", 32'(bus.PCSrcD), 32'h0);
      chk("bne_nt_mis", 32'(bus.MispredictD), 32'h1);
      tick();
      chk("bne_nt_flush", bus.InstrD, 32'h0);

      // Stall outranks the mispredict flush
      set_reg(5'd2, 32'd3);  // r1 = r2 = 3
      bus.InstrF = 32'h1022_0003; bus.PCF = 32'h40; bus.PCPlus4F = 32'h44; bus.JumpPredictF = 1'b0;
      tick();
      bus.StallD = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.InstrF = 32'hABCD_0000 + 32'(i);
         tick();
         chk("stall_hold", bus.InstrD, 32'h1022_0003);
         chk("stall_mis", 32'(bus.MispredictD), 32'h1);
      end
      bus.StallD = 1'b0;
      tick();
      chk("stall_flush", bus.InstrD, 32'h0);

      // Forwarding into the branch compare
      set_reg(5'd1, 32'd0);
      set_reg(5'd2, 32'd5);
      bus.InstrF = 32'h1022_0003; bus.JumpPredictF = 1'b0;
      tick();
      bus.ForwardAD = 1'b1; bus.ALUOutM = 32'd5;
      #1;
      chk("fwd_a_on", 32'(bus.PCSrcD), 32'h1);
      bus.ForwardAD = 1'b0;
      #1;
      chk("fwd_a_off", 32'(bus.PCSrcD), 32'h0);
      bus.ForwardBD = 1'b1; bus.ALUOutM = 32'd0;
      #1;
      chk("fwd_b_on", 32'(bus.PCSrcD), 32'h1);
      bus.ForwardBD = 1'b0;

      // Mid-stream reset ignores stall and clears the register file
      bus.InstrF = 32'h0022_0000;
      tick();
      rst = 1'b1; bus.StallD = 1'b1;
      tick();
      rst = 1'b0; bus.StallD = 1'b0;
      #1;
      chk("mid_rst_instr", bus.InstrD, 32'h0);
      check_all("mid_rst");
      bus.InstrF = 32'h0022_0000;
      tick();
      chk("mid_rst_r2", bus.RD2D, 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [5:0] op;
         case ($urandom_range(0, 3))
            0: op = 6'b000100;
            1: op = 6'b000101;
            2: op = 6'b000000;
            default: op = 6'b100011;
         endcase
         rst              = ($urandom_range(0, 63) == 0);
         bus.StallD       = ($urandom_range(0, 4) == 0);
         bus.InstrF       = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
         bus.PCF          = $urandom;
         bus.PCPlus4F     = bus.PCF + 32'd4;
         bus.JumpPredictF = 1'($urandom);
         bus.ForwardAD    = ($urandom_range(0, 3) == 0);
         bus.ForwardBD    = ($urandom_range(0, 3) == 0);
         bus.ALUOutM      = 32'($urandom_range(0, 3));
         bus.RegWriteW    = 1'($urandom);
         bus.WriteRegW    = 5'($urandom_range(0, 7));
         bus.ResultW      = 32'($urandom_range(0, 3));
         #1;
         check_all("rand");
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
